fft_frame_loader: RTL and testbench

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_frame_loader.sv | 90 +++++++++
 tb/tb_fft_frame_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, loader state encoding and the
// 6-bit bit-reversal used to present samples in FFT input order.
package fft_pkg;

  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int DW    = 32;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_FILL = 1'b1
  } ld_state_e;

  function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] n);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = n[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// Collects a 64-sample stream into a bit-reversed shadow buffer and hands the
// whole frame to the FFT stage in one cycle, flagging framing errors.
module fft_frame_loader #(
  parameter int N  = 64,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_last,
  output logic [N*DW-1:0]      frame_flat,
  output logic                 frame_ready,
  output logic                 frame_err,
  output logic [15:0]          frame_count
);

  import fft_pkg::LOG2N;
  import fft_pkg::bitrev6;
  import fft_pkg::ld_state_e;
  import fft_pkg::LD_IDLE;
  import fft_pkg::LD_FILL;

  ld_state_e            state, state_nxt;
  logic [LOG2N-1:0]     idx, idx_nxt;
  logic [LOG2N-1:0]     wr_slot;
  logic                 hs;
  logic                 complete;
  logic                 err_nxt;
  logic signed [DW-1:0] shadow [N];

  // The loader never back-pressures; only reset withholds ready.
  assign s_ready = ~rst;
  assign hs      = s_valid & s_ready;
  assign wr_slot = bitrev6(idx);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    complete  = 1'b0;
    err_nxt   = 1'b0;
    if (hs) begin
      if (idx == LOG2N'(N-1)) begin
        // 64th sample: deliver regardless, but a missing s_last is still an error.
        complete  = 1'b1;
        err_nxt   = ~s_last;
        idx_nxt   = '0;
        state_nxt = LD_IDLE;
      end else if (s_last) begin
        err_nxt   = 1'b1;
        idx_nxt   = '0;
        state_nxt = LD_IDLE;
      end else begin
        idx_nxt   = idx + 1'b1;
        state_nxt = LD_FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LD_IDLE;
      idx         <= '0;
      frame_ready <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      frame_flat  <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      frame_ready <= complete;
      frame_err   <= err_nxt;
      if (complete) begin
        frame_count <= frame_count + 16'd1;
        // The final sample bypasses the shadow buffer so it lands on this same edge.
        for (int k = 0; k < N; k++) begin
          if (LOG2N'(k) == wr_slot) frame_flat[DW*k +: DW] <= s_data;
          else                      frame_flat[DW*k +: DW] <= shadow[k];
        end
      end
    end
  end

  // Shadow buffer carries no reset; every delivered frame rewrites all slots.
  always_ff @(posedge clk) begin
    if (hs) shadow[wr_slot] <= s_data;
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed-plus-random bench for fft_frame_loader against an array model of
// the bit-reversed frame assembly.
module tb_fft_frame_loader;

  localparam int N  = 64;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 s_last;
  logic [N*DW-1:0]      frame_flat;
  logic                 frame_ready;
  logic                 frame_err;
  logic [15:0]          frame_count;

  fft_frame_loader #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .frame_flat  (frame_flat),
    .frame_ready (frame_ready),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Activity observed each cycle between edges
  int cyc = 0;
  int ready_cnt = 0, err_cnt = 0, both_cnt = 0, flat_bad = 0;
  int last_ready_cyc = 0, prev_ready_cyc = 0;
  logic [N*DW-1:0] prev_flat;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_ready === 1'b1) begin
      ready_cnt++;
      prev_ready_cyc = last_ready_cyc;
      last_ready_cyc = cyc;
    end
    if (frame_err === 1'b1) err_cnt++;
    if (frame_ready === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (rst === 1'b0 && frame_flat !== prev_flat && frame_ready !== 1'b1) flat_bad++;
    prev_flat = frame_flat;
  end

  logic [DW-1:0] fv [N];

  function automatic int rev(input int n);
    int r = 0;
    int v = n;
    for (int b = 0; b < 6; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = $urandom;
    s_last  = 1'($urandom);
  endtask

  task automatic run_frame(input int maxgap, input logic last_end);
    for (int n = 0; n < N; n++) begin
      send(fv[n], (n == N-1) ? last_end : 1'b0);
      if (maxgap > 0 && n < N-1) idle($urandom_range(maxgap));
    end
  endtask

  task automatic check_frame(input string tag);
    for (int n = 0; n < N; n++) begin
      check($sformatf("%s slot%0d", tag, rev(n)), 64'(frame_flat[DW*rev(n) +: DW]), 64'(fv[n]));
    end
  endtask

  task automatic random_fv();
    for (int n = 0; n < N; n++) fv[n] = $urandom;
  endtask

  int r0, e0, b0;

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;

    // Reset held three cycles
    idle(3);
    check("rst frame_flat_zero", 64'(frame_flat == '0), 64'd1);
    check("rst frame_ready", 64'(frame_ready), 64'd0);
    check("rst frame_err", 64'(frame_err), 64'd0);
    check("rst frame_count", 64'(frame_count), 64'd0);
    check("rst s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post-rst s_ready", 64'(s_ready), 64'd1);

    // Single contiguous frame, values n+1
    for (int n = 0; n < N; n++) fv[n] = DW'(n + 1);
    run_frame(0, 1'b1);
    check("single ready_pulse", 64'(frame_ready), 64'd1);
    check("single err", 64'(frame_err), 64'd0);
    check("single slot0", 64'(frame_flat[DW*0 +: DW]), 64'd1);
    check("single slot1", 64'(frame_flat[DW*1 +: DW]), 64'd33);
    check("single slot32", 64'(frame_flat[DW*32 +: DW]), 64'd2);
    check("single slot63", 64'(frame_flat[DW*63 +: DW]), 64'd64);
    check("single count", 64'(frame_count), 64'd1);
    check_frame("single");
    idle(1);
    check("single ready_drop", 64'(frame_ready), 64'd0);
    check("single pulses", 64'(ready_cnt), 64'd1);
    check("single err_pulses", 64'(err_cnt), 64'd0);

    // Same data with random idle gaps on s_valid
    r0 = ready_cnt;
    run_frame(5, 1'b1);
    idle(2);
    check_frame("gapped");
    check("gapped pulses", 64'(ready_cnt - r0), 64'd1);
    check("gapped count", 64'(frame_count), 64'd2);

    // Early s_last discards the partial frame
    r0 = ready_cnt; e0 = err_cnt;
    for (int n = 0; n <= 10; n++) send($urandom, (n == 10) ? 1'b1 : 1'b0);
    idle(2);
    check("early err_pulse", 64'(err_cnt - e0), 64'd1);
    check("early no_ready", 64'(ready_cnt - r0), 64'd0);
    check("early count_hold", 64'(frame_count), 64'd2);
    for (int n = 0; n < N; n++) fv[n] = DW'(101 + n);
    run_frame(0, 1'b1);
    idle(1);
    check("early slot1", 64'(frame_flat[DW*1 +: DW]), 64'd133);
    check_frame("after_early");
    check("after_early count", 64'(frame_count), 64'd3);

    // Back-to-back frames with no gap
    r0 = ready_cnt;
    random_fv();
    run_frame(0, 1'b1);
    random_fv();
    run_frame(0, 1'b1);
    idle(1);
    check_frame("b2b second");
    check("b2b pulses", 64'(ready_cnt - r0), 64'd2);
    check("b2b spacing", 64'(last_ready_cyc - prev_ready_cyc), 64'd64);
    check("b2b count", 64'(frame_count), 64'd5);
    check("flat stable off-pulse", 64'(flat_bad), 64'd0);

    // Missing s_last on the 64th sample: delivered and flagged together
    b0 = both_cnt; e0 = err_cnt;
    random_fv();
    run_frame(2, 1'b0);
    check("nolast ready", 64'(frame_ready), 64'd1);
    check("nolast err", 64'(frame_err), 64'd1);
    idle(1);
    check("nolast both_pulse", 64'(both_cnt - b0), 64'd1);
    check("nolast err_pulses", 64'(err_cnt - e0), 64'd1);
    check_frame("nolast");
    check("nolast count", 64'(frame_count), 64'd6);

    // Reset in the middle of a frame
    r0 = ready_cnt; e0 = err_cnt;
    for (int n = 0; n < 30; n++) send($urandom, 1'b0);
    rst = 1'b1;
    idle(2);
    check("midrst s_ready", 64'(s_ready), 64'd0);
    check("midrst flat_zero", 64'(frame_flat == '0), 64'd1);
    rst = 1'b0;
    idle(1);
    check("midrst count", 64'(frame_count), 64'd0);
    check("midrst no_ready", 64'(ready_cnt - r0), 64'd0);
    check("midrst no_err", 64'(err_cnt - e0), 64'd0);
    random_fv();
    run_frame(1, 1'b1);
    idle(1);
    check_frame("midrst frame");
    check("midrst next_count", 64'(frame_count), 64'd1);
    check("midrst one_pulse", 64'(ready_cnt - r0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
